adder_share_arbiter: RTL and testbench

- Shares one combinational 12-bit BrentKung adder instance among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on each requester port.
- Drives the adder's interleaved operand bus, captures the 13-bit result into a response register, and returns it tagged with the requester ID.
- Sits between the requesters and the shared adder; the adder is instantiated beside this block, not inside it.

---
 rtl/adder_share_arbiter.sv | 91 +++++++++
 tb/tb_adder_share_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external 12-bit adder among NREQ requesters.
// Grants drive the adder's interleaved operand bus; the result is registered and tagged with the winner's ID.
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*12-1:0] req_a,
  input  logic [NREQ*12-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [23:0]       add_in,
  input  logic [12:0]       add_out,
  output logic              rsp_valid,
  output logic [12:0]       rsp_sum,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic [CNTW-1:0]   grant_cnt,
  output logic [CNTW-1:0]   stall_cnt
);
  logic [IDW-1:0]  ptr_q, ptr_d, gnt_idx, cand;
  logic            found, free, accept;
  logic            rsp_valid_q, rsp_valid_d;
  logic [12:0]     rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [CNTW-1:0] grant_q, grant_d, stall_q, stall_d;
  logic [11:0]     op_a, op_b;

  // first valid requester at or after the pointer, wrapping modulo NREQ
  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr_q;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign free      = !rsp_valid_q || rsp_ready;
  assign accept    = free && found;
  assign req_ready = accept ? NREQ'(1) << gnt_idx : '0;
  assign op_a      = req_a[12*gnt_idx +: 12];
  assign op_b      = req_b[12*gnt_idx +: 12];

  always_comb begin
    add_in = '0;
    for (int k = 0; k < 12; k++) begin
      add_in[2*k]   = op_a[k];
      add_in[2*k+1] = op_b[k];
    end
  end

  always_comb begin
    ptr_d       = accept ? (gnt_idx == IDW'(NREQ-1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    rsp_valid_d = accept || (rsp_valid_q && !rsp_ready);
    rsp_sum_d   = accept ? add_out : rsp_sum_q;
    rsp_id_d    = accept ? gnt_idx : rsp_id_q;
    grant_d     = (accept && !(&grant_q)) ? grant_q + 1'b1 : grant_q;
    stall_d     = (rsp_valid_q && !rsp_ready && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      grant_q     <= '0;
      stall_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      grant_q     <= grant_d;
      stall_q     <= stall_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign grant_cnt = grant_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed-vector bench with a response scoreboard and a behavioural adder beside the DUT.
module tb_adder_share_arbiter;
  localparam int CW = 6;
  localparam logic [CW-1:0] CMAX = '1;
  logic           clk = 1'b0, rst = 1'b1;
  logic [3:0]     req_valid = '0, req_ready;
  logic [47:0]    req_a = '0, req_b = '0;
  logic [23:0]    add_in;
  logic [12:0]    add_out, rsp_sum;
  logic           rsp_valid, rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [CW-1:0]  grant_cnt, stall_cnt;
  int             vectors = 0, miscompares = 0;
  logic [14:0]    sb[$];
  logic [11:0]    ca[4], cb[4];
  logic           m_rv = 1'b0;
  logic [CW-1:0]  m_g = '0, m_s = '0;

  adder_share_arbiter #(.NREQ(4), .IDW(2), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_in(add_in), .add_out(add_out), .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .grant_cnt(grant_cnt), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  // the shared adder lives outside the arbiter
  always_comb begin
    logic [11:0] ua, ub;
    ua = '0;
    ub = '0;
    for (int k = 0; k < 12; k++) begin
      ua[k] = add_in[2*k];
      ub[k] = add_in[2*k+1];
    end
    add_out = {1'b0, ua} + {1'b0, ub};
  end

  function automatic logic [23:0] pack(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] p;
    p = '0;
    for (int k = 0; k < 12; k++) begin
      p[2*k]   = a[k];
      p[2*k+1] = b[k];
    end
    return p;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [11:0] a, input logic [11:0] b);
    req_valid[i] = 1'b1;
    req_a[i*12 +: 12] = a;
    req_b[i*12 +: 12] = b;
    ca[i] = a;
    cb[i] = b;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  // one cycle with a hand-predicted grant (-1 = none); pushes the expected response
  task automatic tick(input int exp);
    logic [3:0] er;
    @(negedge clk);
    er = (exp >= 0) ? 4'(1 << exp) : 4'h0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("grant_cnt", 32'(grant_cnt), 32'(m_g));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_s));
    if (exp >= 0) begin
      chk("add_in", 32'(add_in), 32'(pack(ca[exp], cb[exp])));
      sb.push_back({2'(exp), 13'({1'b0, ca[exp]} + {1'b0, cb[exp]})});
    end
    if (m_rv && !rsp_ready && m_s != CMAX) m_s++;
    if (exp >= 0 && m_g != CMAX) m_g++;
    m_rv = (exp >= 0) || (m_rv && !rsp_ready);
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted response is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("sb_nonempty", 32'(rsp_sum), 32'hFFFF_FFFF);
      else begin
        logic [14:0] e;
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e[14:13]));
        chk("rsp_sum", 32'(rsp_sum), 32'(e[12:0]));
      end
    end
  end

  // requester rule: a pending request keeps valid and operands until accepted
  logic [3:0]  pend = '0;
  logic [47:0] pa, pb;
  always @(negedge clk) begin
    if (rst) pend = '0;
    else begin
      for (int i = 0; i < 4; i++)
        if (pend[i])
          assert (req_valid[i] && req_a[i*12 +: 12] == pa[i*12 +: 12] && req_b[i*12 +: 12] == pb[i*12 +: 12])
          else begin
            miscompares++;
            $display("FAIL requester_rule: req %0d changed while pending", i);
          end
      pend = req_valid & ~req_ready;
      pa = req_a;
      pb = req_b;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [11:0] ra[8] = '{12'h0A5, 12'h3C0, 12'h7FF, 12'h800, 12'h123, 12'hFFE, 12'h001, 12'h9AB};
  logic [11:0] rb[8] = '{12'h05A, 12'h0C3, 12'h001, 12'h800, 12'h321, 12'h002, 12'hFFF, 12'h111};
  logic [11:0] sa[3] = '{12'h000, 12'hFFF, 12'hAAA};
  logic [11:0] sbv[3] = '{12'h000, 12'hFFF, 12'h555};
  logic [12:0] se[3] = '{13'h0000, 13'h1FFE, 13'h0FFF};

  initial begin
    logic [12:0] hv;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_sum", 32'(rsp_sum), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_grant_cnt", 32'(grant_cnt), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    rst = 1'b0;
    // single request
    set_req(0, 12'hFFF, 12'h001);
    tick(0);
    clr_req(0);
    chk("single_sum", 32'(rsp_sum), 32'h1000);
    chk("single_id", 32'(rsp_id), 0);
    chk("single_grants", 32'(grant_cnt), 1);
    // rotation with all four requesting; pointer is now 1
    for (int g = 0; g < 4; g++) set_req((1 + g) % 4, ra[g], rb[g]);
    for (int g = 0; g < 8; g++) begin
      tick((1 + g) % 4);
      if (g < 4) set_req((1 + g) % 4, ra[g+4], rb[g+4]);
      else clr_req((1 + g) % 4);
    end
    // backpressure on the last rotation response
    hv = {1'b0, ra[7]} + {1'b0, rb[7]};
    rsp_ready = 1'b0;
    set_req(2, 12'h123, 12'h456);
    for (int c = 0; c < 5; c++) begin
      tick(-1);
      chk("bp_sum_hold", 32'(rsp_sum), 32'(hv));
      chk("bp_id_hold", 32'(rsp_id), 0);
    end
    chk("bp_stall5", 32'(stall_cnt), 5);
    rsp_ready = 1'b1;
    tick(2);
    clr_req(2);
    // pointer is 3: wrap past 3 and 0, take 1, then 2
    set_req(1, 12'h111, 12'h222);
    set_req(2, 12'h333, 12'h444);
    tick(1);
    clr_req(1);
    tick(2);
    clr_req(2);
    tick(-1);
    // operand corners then random operands
    for (int v = 0; v < 3; v++) begin
      set_req(v, sa[v], sbv[v]);
      tick(v);
      clr_req(v);
      chk("corner_sum", 32'(rsp_sum), 32'(se[v]));
    end
    for (int v = 0; v < 8; v++) begin
      set_req(v % 4, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
      tick(v % 4);
      clr_req(v % 4);
    end
    tick(-1);
    // asynchronous reset with a response pending
    set_req(1, 12'h0F0, 12'h00F);
    tick(1);
    clr_req(1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_grant_cnt", 32'(grant_cnt), 0);
    chk("arst_stall_cnt", 32'(stall_cnt), 0);
    sb.delete();
    m_rv = 1'b0;
    m_g = '0;
    m_s = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    set_req(0, 12'h00A, 12'h00B);
    set_req(3, 12'h0C0, 12'h0D0);
    tick(0);
    clr_req(0);
    tick(3);
    clr_req(3);
    tick(-1);
    // counter saturation
    for (int v = 0; v < 66; v++) begin
      set_req(v % 4, 12'(v), 12'(3 * v));
      tick(v % 4);
      clr_req(v % 4);
    end
    chk("grant_sat", 32'(grant_cnt), 32'(CMAX));
    rsp_ready = 1'b0;
    for (int c = 0; c < 70; c++) tick(-1);
    chk("stall_sat", 32'(stall_cnt), 32'(CMAX));
    rsp_ready = 1'b1;
    tick(-1);
    repeat (2) tick(-1);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
